// File: rtl/hlsm_shared_mult_ctrl.sv
// Four-product HLSM controller that time-shares one signed multiplier across i=a*b, j=c*d, k=e*f, l=g*h.
// Optional macro MULT_PIPE_EN registers the multiplier output and adds one state (Done one cycle later).
module hlsm_shared_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] l,
  output logic             Done,
  output logic             Busy
);

  // state | meaning
  // WAIT  | idle, operands captured when Start is seen
  // S1    | multiply a*b (written to i, or to P when pipelined)
  // S2    | multiply c*d
  // S3    | multiply e*f
  // S4    | multiply g*h
  // S5    | pipelined build only: retire last product into l
  // FINAL | Done asserted, return to WAIT
  typedef enum logic [2:0] {
    WAIT,
    S1,
    S2,
    S3,
    S4,
`ifdef MULT_PIPE_EN
    S5,
`endif
    FINAL
  } state_t;

  state_t state;
  logic [WIDTH-1:0] cap_a, cap_b, cap_c, cap_d, cap_e, cap_f, cap_g, cap_h;
  logic [WIDTH-1:0] mx, my, prod;

  always_comb begin
    mx = cap_a;
    my = cap_b;
    case (state)
      S2:      begin mx = cap_c; my = cap_d; end
      S3:      begin mx = cap_e; my = cap_f; end
      S4:      begin mx = cap_g; my = cap_h; end
      default: begin mx = cap_a; my = cap_b; end
    endcase
  end

  // Low WIDTH bits of a two's-complement product do not depend on signedness,
  // so the truncated signed product is formed directly at WIDTH bits.
  assign prod = mx * my;

  assign Done = (state == FINAL);
  assign Busy = (state != WAIT);

`ifdef MULT_PIPE_EN
  logic [WIDTH-1:0] p;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= WAIT;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      l     <= '0;
      cap_a <= '0;
      cap_b <= '0;
      cap_c <= '0;
      cap_d <= '0;
      cap_e <= '0;
      cap_f <= '0;
      cap_g <= '0;
      cap_h <= '0;
`ifdef MULT_PIPE_EN
      p     <= '0;
`endif
    end else begin
      case (state)
        WAIT: begin
          if (Start) begin
            cap_a <= a;
            cap_b <= b;
            cap_c <= c;
            cap_d <= d;
            cap_e <= e;
            cap_f <= f;
            cap_g <= g;
            cap_h <= h;
            state <= S1;
          end
        end
`ifdef MULT_PIPE_EN
        S1: begin p <= prod;           state <= S2;    end
        S2: begin i <= p; p <= prod;   state <= S3;    end
        S3: begin j <= p; p <= prod;   state <= S4;    end
        S4: begin k <= p; p <= prod;   state <= S5;    end
        S5: begin l <= p;              state <= FINAL; end
`else
        S1: begin i <= prod;           state <= S2;    end
        S2: begin j <= prod;           state <= S3;    end
        S3: begin k <= prod;           state <= S4;    end
        S4: begin l <= prod;           state <= FINAL; end
`endif
        FINAL:   state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_shared_mult_ctrl.sv
// Self-checking bench for hlsm_shared_mult_ctrl against a plain-arithmetic product model.
module tb_hlsm_shared_mult_ctrl;
`ifdef MULT_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int PER = LAT + 2;

  logic Clk = 1'b0;
  logic Rst, Start;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [15:0] i, j, k, l;
  logic Done, Busy;

  int total = 0;
  int bad = 0;
  logic [15:0] op[8];
  logic [15:0] expv[4];
  logic [15:0] got[4];

  always #5 Clk = ~Clk;

  hlsm_shared_mult_ctrl #(.WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .i(i), .j(j), .k(k), .l(l), .Done(Done), .Busy(Busy)
  );

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_ops();
    a = op[0]; b = op[1]; c = op[2]; d = op[3];
    e = op[4]; f = op[5]; g = op[6]; h = op[7];
    for (int m = 0; m < 4; m++) expv[m] = ref_mul(op[2*m], op[2*m+1]);
  endtask

  task automatic rand_ops();
    for (int n = 0; n < 8; n++) op[n] = 16'($urandom);
    drive_ops();
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    rand_ops();
    Start = 1'($urandom);
    repeat (3) tick();
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== 16'h0) begin
        bad++; $display("FAIL reset_out%0d got=%h exp=0000", m, got[m]);
      end
    end
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    Start = 1'b0;
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_basic(input bit zero_after);
    int n;
    logic [15:0] want[4];
    want = '{16'hFFF4, 16'd24464, 16'h0001, 16'hFFFE};
    op = '{16'd3, -16'sd4, 16'd300, 16'd300, 16'hFFFF, 16'hFFFF, 16'd32767, 16'd2};
    drive_ops();
    start_pulse();
    if (zero_after) begin
      a = 0; b = 0; c = 0; d = 0; e = 0; f = 0; g = 0; h = 0;
    end
    wait_done(n);
    total++;
    if (n != LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", n, LAT); end
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== want[m]) begin
        bad++; $display("FAIL basic_res%0d zero=%0d got=%h exp=%h", m, zero_after, got[m], want[m]);
      end
    end
    tick();
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", Done); end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", Busy); end
  endtask

  task automatic test_async_reset();
    rand_ops();
    start_pulse();
    tick();
    #3;
    Rst = 1'b1;
    #1;
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== 16'h0) begin
        bad++; $display("FAIL async_rst_out%0d got=%h exp=0000", m, got[m]);
      end
    end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", Busy); end
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_start_busy();
    int ndone, first_done, n;
    rand_ops();
    ndone = 0;
    first_done = -1;
    start_pulse();
    for (int cy = 1; cy <= LAT + 8; cy++) begin
      Start = (cy == 2 || cy == LAT + 1);
      tick();
      if (Done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = cy;
      end
    end
    Start = 1'b0;
    total++;
    if (ndone != 1) begin bad++; $display("FAIL busy_ignore_count got=%0d exp=1", ndone); end
    total++;
    if (first_done != LAT) begin bad++; $display("FAIL busy_ignore_first got=%0d exp=%0d", first_done, LAT); end
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== expv[m]) begin
        bad++; $display("FAIL busy_ignore_res%0d got=%h exp=%h", m, got[m], expv[m]);
      end
    end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle got=%b exp=0", Busy); end
    rand_ops();
    start_pulse();
    wait_done(n);
    total++;
    if (n != LAT) begin bad++; $display("FAIL busy_restart_latency got=%0d exp=%0d", n, LAT); end
    tick();
  endtask

  task automatic test_continuous();
    logic exp_d, exp_b;
    rand_ops();
    for (int cy = 1; cy <= 20; cy++) begin
      Start = 1'b1;
      tick();
      exp_d = (cy >= 1 + LAT) && (((cy - 1 - LAT) % PER) == 0);
      exp_b = (cy % PER) != 0;
      total++;
      if (Done !== exp_d) begin bad++; $display("FAIL cont_done cyc=%0d got=%b exp=%b", cy, Done, exp_d); end
      total++;
      if (Busy !== exp_b) begin bad++; $display("FAIL cont_busy cyc=%0d got=%b exp=%b", cy, Busy, exp_b); end
    end
    Start = 1'b0;
    repeat (PER) tick();
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== expv[m]) begin
        bad++; $display("FAIL cont_res%0d got=%h exp=%h", m, got[m], expv[m]);
      end
    end
  endtask

  task automatic test_abort();
    int ndone, n;
    rand_ops();
    start_pulse();
    tick();
    tick();
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b exp=1", Busy); end
    #2;
    Rst = 1'b1;
    #1;
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== 16'h0) begin
        bad++; $display("FAIL abort_out%0d got=%h exp=0000", m, got[m]);
      end
    end
    tick();
    Rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      tick();
      if (Done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    rand_ops();
    start_pulse();
    wait_done(n);
    total++;
    if (n != LAT) begin bad++; $display("FAIL abort_rerun_latency got=%0d exp=%0d", n, LAT); end
    got = '{i, j, k, l};
    for (int m = 0; m < 4; m++) begin
      total++;
      if (got[m] !== expv[m]) begin
        bad++; $display("FAIL abort_rerun_res%0d got=%h exp=%h", m, got[m], expv[m]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      rand_ops();
      repeat ($urandom_range(0, 3)) tick();
      start_pulse();
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      e = 16'($urandom); f = 16'($urandom); g = 16'($urandom); h = 16'($urandom);
      wait_done(n);
      total++;
      if (n != LAT) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", r, n, LAT); end
      got = '{i, j, k, l};
      for (int m = 0; m < 4; m++) begin
        total++;
        if (got[m] !== expv[m]) begin
          bad++; $display("FAIL rand%0d_res%0d got=%h exp=%h", r, m, got[m], expv[m]);
        end
      end
      tick();
    end
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    {a, b, c, d, e, f, g, h} = '0;
    #1;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_async_reset();
    test_start_busy();
    test_continuous();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
